// File: rtl/gpr_pkg.sv
// Shared types and sizes for the GPR writeback path.
package gpr_pkg;

  localparam int XLEN   = 32;
  localparam int NREG   = 32;
  localparam int REG_AW = 5;
  localparam int ALU_FIFO_DEPTH_DEF = 2;

  typedef logic [REG_AW-1:0] reg_addr_t;
  typedef logic [XLEN-1:0]   reg_data_t;

  typedef struct packed {
    reg_addr_t rd;
    reg_data_t data;
  } wb_req_t;

endpackage

// File: rtl/gpr_wb_ctrl_if.sv
// Decoder/ALU/LSU side of the GPR writeback controller, plus the GPR write port.
interface gpr_wb_ctrl_if;
  import gpr_pkg::*;

  logic      iss_valid;
  reg_addr_t iss_rd;
  logic      iss_ready;

  logic      alu_valid;
  reg_addr_t alu_rd;
  reg_data_t alu_data;
  logic      alu_ready;

  logic      lsu_valid;
  reg_addr_t lsu_rd;
  reg_data_t lsu_data;
  logic      lsu_ready;

  reg_addr_t Ra;
  reg_addr_t Rb;
  logic      hazA;
  logic      hazB;

  logic      RegWr;
  reg_addr_t Rw;
  reg_data_t busW;
  logic      sb_err;

  modport master (
    output iss_valid, iss_rd,
    output alu_valid, alu_rd, alu_data,
    output lsu_valid, lsu_rd, lsu_data,
    output Ra, Rb,
    input  iss_ready, alu_ready, lsu_ready,
    input  hazA, hazB,
    input  RegWr, Rw, busW, sb_err
  );

  modport slave (
    input  iss_valid, iss_rd,
    input  alu_valid, alu_rd, alu_data,
    input  lsu_valid, lsu_rd, lsu_data,
    input  Ra, Rb,
    output iss_ready, alu_ready, lsu_ready,
    output hazA, hazB,
    output RegWr, Rw, busW, sb_err
  );

endinterface

// File: rtl/wb_fifo.sv
// In-order skid buffer for ALU writeback requests.
// Accepts a push while full as long as the head pops at the same edge.
module wb_fifo
  import gpr_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic    i_clk,
  input  logic    i_rst,
  input  logic    i_push,
  input  logic    i_pop,
  input  wb_req_t i_data,
  output wb_req_t o_head,
  output logic    o_full,
  output logic    o_empty
);

  localparam int AW = $clog2(DEPTH);

  wb_req_t       r_mem [DEPTH];
  logic [AW:0]   r_wr_ptr;
  logic [AW:0]   r_rd_ptr;
  logic          w_do_push;
  logic          w_do_pop;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);
  assign o_head    = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/gpr_wb_ctrl.sv
// GPR write-port controller: merges LSU and ALU results into one registered write
// per cycle and keeps the per-register busy scoreboard that drives the read hazards.
module gpr_wb_ctrl
  import gpr_pkg::*;
#(
  parameter int ALU_FIFO_DEPTH = ALU_FIFO_DEPTH_DEF
) (
  input  logic         WrClk,
  input  logic         rst,
  gpr_wb_ctrl_if.slave bus
);

  logic [NREG-1:0] r_busy;
  logic            r_regwr;
  reg_addr_t       r_rw;
  reg_data_t       r_busw;
  logic            r_sb_err;

  logic [NREG-1:0] w_busy_nxt;
  logic            w_iss_acc;
  logic            w_alu_acc;
  logic            w_bypass;
  logic            w_push;
  logic            w_pop;
  logic            w_fifo_full;
  logic            w_fifo_empty;
  logic            w_sel_valid;
  wb_req_t         w_sel;
  wb_req_t         w_alu_req;
  wb_req_t         w_lsu_req;
  wb_req_t         w_head;

  assign w_alu_req = '{rd: bus.alu_rd, data: bus.alu_data};
  assign w_lsu_req = '{rd: bus.lsu_rd, data: bus.lsu_data};

  assign bus.iss_ready = !rst && !r_busy[bus.iss_rd];
  assign bus.alu_ready = !rst && !w_fifo_full;
  assign bus.lsu_ready = !rst;

  assign w_iss_acc = bus.iss_valid && bus.iss_ready;
  assign w_alu_acc = bus.alu_valid && bus.alu_ready;

  // The ALU result skips the queue only when nothing older or higher-priority competes.
  assign w_bypass = w_alu_acc && w_fifo_empty && !bus.lsu_valid;
  assign w_push   = w_alu_acc && !w_bypass;
  assign w_pop    = !w_fifo_empty && !bus.lsu_valid;

  wb_fifo #(
    .DEPTH (ALU_FIFO_DEPTH)
  ) u_alu_fifo (
    .i_clk   (WrClk),
    .i_rst   (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (w_alu_req),
    .o_head  (w_head),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  always_comb begin
    w_sel_valid = 1'b0;
    w_sel       = '0;
    if (bus.lsu_valid) begin
      w_sel_valid = 1'b1;
      w_sel       = w_lsu_req;
    end else if (!w_fifo_empty) begin
      w_sel_valid = 1'b1;
      w_sel       = w_head;
    end else if (w_alu_acc) begin
      w_sel_valid = 1'b1;
      w_sel       = w_alu_req;
    end
  end

  // Retirement clears first so a same-edge issue to the same register wins.
  always_comb begin
    w_busy_nxt = r_busy;
    if (r_regwr) w_busy_nxt[r_rw] = 1'b0;
    if (w_iss_acc) w_busy_nxt[bus.iss_rd] = 1'b1;
    w_busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge WrClk) begin
    if (rst) begin
      r_busy   <= '0;
      r_regwr  <= 1'b0;
      r_rw     <= '0;
      r_busw   <= '0;
      r_sb_err <= 1'b0;
    end else begin
      r_busy <= w_busy_nxt;
      if (w_sel_valid && (w_sel.rd != '0)) begin
        r_regwr <= 1'b1;
        r_rw    <= w_sel.rd;
        r_busw  <= w_sel.data;
        if (!r_busy[w_sel.rd]) r_sb_err <= 1'b1;
      end else begin
        r_regwr <= 1'b0;
      end
    end
  end

  // No bypass: a reader stalls through the retiring cycle itself.
  assign bus.hazA = (bus.Ra != '0) && r_busy[bus.Ra];
  assign bus.hazB = (bus.Rb != '0) && r_busy[bus.Rb];

  assign bus.RegWr  = r_regwr;
  assign bus.Rw     = r_rw;
  assign bus.busW   = r_busw;
  assign bus.sb_err = r_sb_err;

endmodule

// File: tb/tb_gpr_wb_ctrl.sv
// Bench for gpr_wb_ctrl: directed scenarios plus a randomized run against a
// queue-based reference model of the writeback path.
module tb_gpr_wb_ctrl;
  import gpr_pkg::*;

  logic WrClk = 1'b0;
  logic rst   = 1'b1;

  gpr_wb_ctrl_if bus();

  gpr_wb_ctrl #(.ALU_FIFO_DEPTH(ALU_FIFO_DEPTH_DEF)) dut (
    .WrClk (WrClk),
    .rst   (rst),
    .bus   (bus)
  );

  always #5 WrClk = ~WrClk;

  int checks = 0;
  int errors = 0;

  // Reference model: busy flags, pending ALU results, registered write port.
  bit        m_busy [NREG];
  wb_req_t   m_q [$];
  bit        m_regwr = 1'b0;
  reg_addr_t m_rw    = '0;
  reg_data_t m_busw  = '0;
  bit        m_sberr = 1'b0;

  reg_addr_t wlog [$];
  bit        pend [NREG];

  task automatic tick();
    bit        r, iv, av, lv, alu_acc, iss_acc, have;
    reg_addr_t ir, ar, lr;
    reg_data_t ad, ld;
    wb_req_t   s;
    bit        busy_old [NREG];
    r  = rst;
    iv = bus.iss_valid; ir = bus.iss_rd;
    av = bus.alu_valid; ar = bus.alu_rd; ad = bus.alu_data;
    lv = bus.lsu_valid; lr = bus.lsu_rd; ld = bus.lsu_data;
    @(posedge WrClk);
    if (r) begin
      foreach (m_busy[i]) m_busy[i] = 1'b0;
      m_q.delete();
      m_regwr = 1'b0; m_rw = '0; m_busw = '0; m_sberr = 1'b0;
    end else begin
      busy_old = m_busy;
      alu_acc  = av && (m_q.size() < ALU_FIFO_DEPTH_DEF);
      iss_acc  = iv && !m_busy[ir];
      have     = 1'b0;
      s        = '0;
      if (alu_acc) begin
        s.rd = ar; s.data = ad;
        m_q.push_back(s);
      end
      if (lv) begin
        have = 1'b1; s.rd = lr; s.data = ld;
      end else if (m_q.size() > 0) begin
        have = 1'b1; s = m_q.pop_front();
      end
      if (m_regwr) m_busy[m_rw] = 1'b0;
      if (iss_acc && ir != '0) m_busy[ir] = 1'b1;
      if (have && s.rd != '0) begin
        if (!busy_old[s.rd]) m_sberr = 1'b1;
        m_regwr = 1'b1; m_rw = s.rd; m_busw = s.data;
      end else begin
        m_regwr = 1'b0;
      end
    end
    #1;
    if (bus.RegWr === 1'b1) wlog.push_back(bus.Rw);
  endtask

  task automatic idle_inputs();
    bus.iss_valid = 1'b0; bus.iss_rd = '0;
    bus.alu_valid = 1'b0; bus.alu_rd = '0; bus.alu_data = '0;
    bus.lsu_valid = 1'b0; bus.lsu_rd = '0; bus.lsu_data = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.iss_valid = 1'b1; bus.iss_rd = 5'd6;
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd5; bus.alu_data = 32'h5555_5555;
    bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd7; bus.lsu_data = 32'h7777_7777;
    bus.Ra = 5'd5; bus.Rb = 5'd7;
    tick(); tick();
    checks++; if (bus.RegWr !== 1'b0) begin errors++; $display("FAIL reset_regwr: got %b want 0", bus.RegWr); end
    checks++; if (bus.Rw !== 5'd0) begin errors++; $display("FAIL reset_rw: got %0d want 0", bus.Rw); end
    checks++; if (bus.busW !== 32'd0) begin errors++; $display("FAIL reset_busw: got %h want 0", bus.busW); end
    checks++; if (bus.sb_err !== 1'b0) begin errors++; $display("FAIL reset_sberr: got %b want 0", bus.sb_err); end
    checks++; if (bus.hazA !== 1'b0 || bus.hazB !== 1'b0) begin errors++; $display("FAIL reset_haz: got %b%b want 00", bus.hazA, bus.hazB); end
    checks++; if ({bus.iss_ready, bus.alu_ready, bus.lsu_ready} !== 3'b000) begin
      errors++; $display("FAIL reset_ready: got %b%b%b want 000", bus.iss_ready, bus.alu_ready, bus.lsu_ready);
    end
    rst = 1'b0;
    idle_inputs();
    tick();
    bus.iss_rd = 5'd5;
    #1;
    checks++; if (bus.iss_ready !== 1'b1) begin errors++; $display("FAIL reset_release_iss_ready: got %b want 1", bus.iss_ready); end
  endtask

  task automatic test_issue_alu();
    bus.iss_valid = 1'b1; bus.iss_rd = 5'd5; bus.Ra = 5'd5; bus.Rb = 5'd0;
    #1;
    checks++; if (bus.hazA !== 1'b0) begin errors++; $display("FAIL issue_haz_before: got %b want 0", bus.hazA); end
    tick();
    bus.iss_valid = 1'b0;
    #1;
    checks++; if (bus.hazA !== 1'b1) begin errors++; $display("FAIL issue_haz_set: got %b want 1", bus.hazA); end
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd5; bus.alu_data = 32'h1234;
    #1;
    checks++; if (bus.alu_ready !== 1'b1) begin errors++; $display("FAIL alu_ready_idle: got %b want 1", bus.alu_ready); end
    tick();
    bus.alu_valid = 1'b0;
    #1;
    checks++; if (bus.RegWr !== 1'b1 || bus.Rw !== 5'd5 || bus.busW !== 32'h1234) begin
      errors++; $display("FAIL alu_bypass_write: got we=%b rw=%0d d=%h want we=1 rw=5 d=1234", bus.RegWr, bus.Rw, bus.busW);
    end
    checks++; if (bus.hazA !== 1'b1) begin errors++; $display("FAIL haz_during_retire: got %b want 1", bus.hazA); end
    tick();
    checks++; if (bus.hazA !== 1'b0 || bus.RegWr !== 1'b0) begin
      errors++; $display("FAIL haz_after_retire: got haz=%b we=%b want 0 0", bus.hazA, bus.RegWr);
    end
  endtask

  task automatic test_collision();
    bus.iss_valid = 1'b1; bus.iss_rd = 5'd3; tick();
    bus.iss_rd = 5'd7; tick();
    bus.iss_valid = 1'b0;
    bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd3; bus.lsu_data = 32'hAAAA_0000;
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd7; bus.alu_data = 32'h7;
    tick();
    idle_inputs();
    #1;
    checks++; if (bus.RegWr !== 1'b1 || bus.Rw !== 5'd3 || bus.busW !== 32'hAAAA_0000) begin
      errors++; $display("FAIL collision_lsu_first: got we=%b rw=%0d d=%h want 1 3 aaaa0000", bus.RegWr, bus.Rw, bus.busW);
    end
    tick();
    checks++; if (bus.RegWr !== 1'b1 || bus.Rw !== 5'd7 || bus.busW !== 32'h7) begin
      errors++; $display("FAIL collision_alu_second: got we=%b rw=%0d d=%h want 1 7 7", bus.RegWr, bus.Rw, bus.busW);
    end
    tick();
    checks++; if (bus.RegWr !== 1'b0) begin errors++; $display("FAIL collision_idle: got %b want 0", bus.RegWr); end
  endtask

  task automatic test_fifo_full();
    reg_addr_t exp_seq [7];
    bit        accepted;
    exp_seq = '{5'd10, 5'd11, 5'd12, 5'd13, 5'd1, 5'd2, 5'd3};
    foreach (exp_seq[i]) begin
      bus.iss_valid = 1'b1; bus.iss_rd = exp_seq[i]; tick();
    end
    bus.iss_valid = 1'b0;
    wlog.delete();
    for (int c = 0; c < 4; c++) begin
      bus.lsu_valid = 1'b1; bus.lsu_rd = 5'(10 + c); bus.lsu_data = 32'(c);
      bus.alu_valid = 1'b1; bus.alu_rd = (c < 2) ? 5'(c + 1) : 5'd3; bus.alu_data = 32'(100 + c);
      #1;
      checks++; if (bus.alu_ready !== (c < 2)) begin
        errors++; $display("FAIL fifo_full_ready c=%0d: got %b want %b", c, bus.alu_ready, (c < 2));
      end
      tick();
    end
    bus.lsu_valid = 1'b0;
    accepted = 1'b0;
    for (int k = 0; k < 8 && !accepted; k++) begin
      #1;
      accepted = bus.alu_ready;
      tick();
    end
    bus.alu_valid = 1'b0;
    checks++; if (!accepted) begin errors++; $display("FAIL fifo_full_timeout: alu rd=3 got ready=0 want 1 within 8 cycles"); end
    repeat (4) tick();
    checks++; if (wlog.size() != 7) begin errors++; $display("FAIL fifo_order_count: got %0d want 7", wlog.size()); end
    for (int i = 0; i < 7 && i < wlog.size(); i++) begin
      checks++; if (wlog[i] !== exp_seq[i]) begin
        errors++; $display("FAIL fifo_order[%0d]: got %0d want %0d", i, wlog[i], exp_seq[i]);
      end
    end
    checks++; if (bus.sb_err !== 1'b0) begin errors++; $display("FAIL fifo_sberr: got %b want 0", bus.sb_err); end
  endtask

  task automatic test_waw_x0();
    bus.iss_valid = 1'b1; bus.iss_rd = 5'd4;
    #1;
    checks++; if (bus.iss_ready !== 1'b1) begin errors++; $display("FAIL waw_first_ready: got %b want 1", bus.iss_ready); end
    tick();
    checks++; if (bus.iss_ready !== 1'b0) begin errors++; $display("FAIL waw_stall: got %b want 0", bus.iss_ready); end
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd4; bus.alu_data = 32'h44;
    tick();
    bus.alu_valid = 1'b0;
    #1;
    checks++; if (bus.RegWr !== 1'b1 || bus.Rw !== 5'd4 || bus.iss_ready !== 1'b0) begin
      errors++; $display("FAIL waw_retiring: got we=%b rw=%0d rdy=%b want 1 4 0", bus.RegWr, bus.Rw, bus.iss_ready);
    end
    tick();
    checks++; if (bus.iss_ready !== 1'b1) begin errors++; $display("FAIL waw_release: got %b want 1", bus.iss_ready); end
    tick();
    bus.iss_valid = 1'b0; bus.Ra = 5'd4;
    #1;
    checks++; if (bus.hazA !== 1'b1) begin errors++; $display("FAIL waw_second_busy: got %b want 1", bus.hazA); end
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd4; bus.alu_data = 32'h45;
    tick();
    bus.alu_valid = 1'b0;
    tick();
    bus.Ra = 5'd0; bus.iss_valid = 1'b1; bus.iss_rd = 5'd0;
    #1;
    checks++; if (bus.iss_ready !== 1'b1) begin errors++; $display("FAIL x0_issue_ready: got %b want 1", bus.iss_ready); end
    tick();
    bus.iss_valid = 1'b0;
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd0; bus.alu_data = 32'h99;
    tick();
    bus.alu_valid = 1'b0;
    #1;
    checks++; if (bus.RegWr !== 1'b0 || bus.hazA !== 1'b0 || bus.sb_err !== 1'b0) begin
      errors++; $display("FAIL x0_write: got we=%b haz=%b err=%b want 0 0 0", bus.RegWr, bus.hazA, bus.sb_err);
    end
  endtask

  task automatic test_err_reset();
    bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd9; bus.lsu_data = 32'h99;
    tick();
    bus.lsu_valid = 1'b0;
    #1;
    checks++; if (bus.sb_err !== 1'b1 || bus.RegWr !== 1'b1 || bus.Rw !== 5'd9) begin
      errors++; $display("FAIL stray_write: got err=%b we=%b rw=%0d want 1 1 9", bus.sb_err, bus.RegWr, bus.Rw);
    end
    tick(); tick();
    checks++; if (bus.sb_err !== 1'b1) begin errors++; $display("FAIL sberr_sticky: got %b want 1", bus.sb_err); end
    for (int r = 20; r < 24; r++) begin
      bus.iss_valid = 1'b1; bus.iss_rd = 5'(r); tick();
    end
    bus.iss_valid = 1'b0;
    bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd22; bus.alu_valid = 1'b1; bus.alu_rd = 5'd20; tick();
    bus.lsu_rd = 5'd23; bus.alu_rd = 5'd21; tick();
    idle_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    wlog.delete();
    bus.Ra = 5'd20; bus.Rb = 5'd21;
    #1;
    checks++; if (bus.sb_err !== 1'b0 || bus.RegWr !== 1'b0) begin
      errors++; $display("FAIL midop_reset_out: got err=%b we=%b want 0 0", bus.sb_err, bus.RegWr);
    end
    checks++; if (bus.hazA !== 1'b0 || bus.hazB !== 1'b0) begin
      errors++; $display("FAIL midop_reset_haz: got %b%b want 00", bus.hazA, bus.hazB);
    end
    repeat (4) tick();
    checks++; if (wlog.size() != 0) begin errors++; $display("FAIL midop_reset_drain: got %0d writes want 0", wlog.size()); end
  endtask

  function automatic int pick_pending(int excl);
    int s;
    s = $urandom_range(1, NREG - 1);
    for (int k = 0; k < NREG - 1; k++) begin
      int r;
      r = 1 + ((s - 1 + k) % (NREG - 1));
      if (pend[r] && r != excl) return r;
    end
    return -1;
  endfunction

  task automatic test_random();
    int  a, l;
    bit  e_iss, e_alu, e_ha, e_hb;
    idle_inputs();
    rst = 1'b1; tick(); rst = 1'b0;
    foreach (pend[i]) pend[i] = 1'b0;
    for (int cyc = 0; cyc < 500; cyc++) begin
      idle_inputs();
      bus.iss_valid = 1'($urandom_range(0, 1));
      bus.iss_rd    = 5'($urandom_range(0, NREG - 1));
      bus.Ra        = 5'($urandom_range(0, NREG - 1));
      bus.Rb        = 5'($urandom_range(0, NREG - 1));
      a = -1; l = -1;
      if ($urandom_range(0, 2) != 0) a = pick_pending(-1);
      if ($urandom_range(0, 2) == 0) l = pick_pending(a);
      if (l < 0 && $urandom_range(0, 39) == 0) begin
        l = $urandom_range(0, NREG - 1);
        if (l == a) l = -1;
      end
      if (a >= 0) begin bus.alu_valid = 1'b1; bus.alu_rd = 5'(a); bus.alu_data = $urandom; end
      if (l >= 0) begin bus.lsu_valid = 1'b1; bus.lsu_rd = 5'(l); bus.lsu_data = $urandom; end
      #1;
      e_iss = !m_busy[bus.iss_rd];
      e_alu = m_q.size() < ALU_FIFO_DEPTH_DEF;
      e_ha  = (bus.Ra != '0) && m_busy[bus.Ra];
      e_hb  = (bus.Rb != '0) && m_busy[bus.Rb];
      checks++; if (bus.RegWr !== m_regwr) begin errors++; $display("FAIL rnd_regwr c=%0d: got %b want %b", cyc, bus.RegWr, m_regwr); end
      checks++; if (bus.Rw !== m_rw) begin errors++; $display("FAIL rnd_rw c=%0d: got %0d want %0d", cyc, bus.Rw, m_rw); end
      checks++; if (bus.busW !== m_busw) begin errors++; $display("FAIL rnd_busw c=%0d: got %h want %h", cyc, bus.busW, m_busw); end
      checks++; if (bus.sb_err !== m_sberr) begin errors++; $display("FAIL rnd_sberr c=%0d: got %b want %b", cyc, bus.sb_err, m_sberr); end
      checks++; if (bus.iss_ready !== e_iss) begin errors++; $display("FAIL rnd_iss_ready c=%0d: got %b want %b", cyc, bus.iss_ready, e_iss); end
      checks++; if (bus.alu_ready !== e_alu) begin errors++; $display("FAIL rnd_alu_ready c=%0d: got %b want %b", cyc, bus.alu_ready, e_alu); end
      checks++; if (bus.lsu_ready !== 1'b1) begin errors++; $display("FAIL rnd_lsu_ready c=%0d: got %b want 1", cyc, bus.lsu_ready); end
      checks++; if (bus.hazA !== e_ha) begin errors++; $display("FAIL rnd_hazA c=%0d: got %b want %b", cyc, bus.hazA, e_ha); end
      checks++; if (bus.hazB !== e_hb) begin errors++; $display("FAIL rnd_hazB c=%0d: got %b want %b", cyc, bus.hazB, e_hb); end
      if (bus.iss_valid && e_iss && bus.iss_rd != '0) pend[bus.iss_rd] = 1'b1;
      if (a >= 0 && e_alu) pend[a] = 1'b0;
      if (l >= 0) pend[l] = 1'b0;
      tick();
    end
  endtask

  initial begin
    idle_inputs();
    bus.Ra = '0; bus.Rb = '0;
    foreach (m_busy[i]) m_busy[i] = 1'b0;
    test_reset();
    test_issue_alu();
    test_collision();
    test_fifo_full();
    test_waw_x0();
    test_err_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
